// File: rtl/mips_mem_bus_if.sv
// Core-side memory port of the multicycle MIPS core.
// The core (master) drives address, store data and store strobe. The memory
// bus (slave) returns read data combinationally in the same cycle.
interface mips_mem_bus_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_ena;
    logic [31:0] mem_rd_data;

    modport master (
        output mem_addr,
        output mem_wr_data,
        output mem_wr_ena,
        input  mem_rd_data
    );

    modport slave (
        input  mem_addr,
        input  mem_wr_data,
        input  mem_wr_ena,
        output mem_rd_data
    );
endinterface

// File: rtl/mips_mem_bus.sv
// Memory-side bus for the multicycle MIPS core.
// Decodes each core access to word RAM or to the IO page. The IO page holds
// the LED register, a free-running cycle counter and a byte TX FIFO that a
// valid/ready consumer drains. Reads are combinational and side-effect free,
// because the core presents the PC on every fetch cycle without a read strobe.
module mips_mem_bus #(
    parameter logic [15:0] IO_BASE_HI     = 16'hFFFF,
    parameter int          RAM_ADDR_WIDTH = 10,
    parameter int          FIFO_DEPTH     = 8,
    parameter int          LED_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rstb,
    mips_mem_bus_if.slave             bus,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]               ram_wr_data,
    output logic                      ram_wr_ena,
    input  logic [31:0]               ram_rd_data,
    output logic [LED_WIDTH-1:0]      led,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [13:0]      OFF_LED       = 14'd0;
    localparam logic [13:0]      OFF_CYCLE     = 14'd1;
    localparam logic [13:0]      OFF_TX_DATA   = 14'd2;
    localparam logic [13:0]      OFF_TX_STATUS = 14'd3;
    localparam logic [PTR_W-1:0] PTR_ONE       = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL      = CNT_W'(FIFO_DEPTH);

    // Architectural state
    logic [LED_WIDTH-1:0] led_r;
    logic [31:0]          cycle_r;
    logic [7:0]           fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic                 tx_valid_r;
    logic                 overflow_r;

    // Decode and control
    logic                 io_sel_s;
    logic [13:0]          word_s;
    logic                 io_wr_s;
    logic                 led_wr_s;
    logic                 cycle_wr_s;
    logic                 status_wr_s;
    logic                 push_req_s;
    logic                 push_ok_s;
    logic                 drop_s;
    logic                 pop_s;
    logic                 full_s;
    logic                 empty_s;
    logic [CNT_W-1:0]     count_nxt_s;
    logic [31:0]          rd_data_s;
    logic                 unused_addr_lsb_s;

    // The byte lane bits are ignored everywhere; all accesses are word accesses.
    assign unused_addr_lsb_s = ^bus.mem_addr[1:0];

    assign io_sel_s    = (bus.mem_addr[31:16] == IO_BASE_HI);
    assign word_s      = bus.mem_addr[15:2];
    assign io_wr_s     = bus.mem_wr_ena & io_sel_s;
    assign led_wr_s    = io_wr_s & (word_s == OFF_LED);
    assign cycle_wr_s  = io_wr_s & (word_s == OFF_CYCLE);
    assign push_req_s  = io_wr_s & (word_s == OFF_TX_DATA);
    assign status_wr_s = io_wr_s & (word_s == OFF_TX_STATUS);

    assign full_s      = (count_r == CNT_FULL);
    assign empty_s     = (count_r == {CNT_W{1'b0}});
    assign pop_s       = tx_valid_r & tx_ready;
    // A full FIFO still takes a byte when the consumer frees a slot this cycle.
    assign push_ok_s   = push_req_s & (~full_s | pop_s);
    assign drop_s      = push_req_s & ~push_ok_s;

    assign ram_addr        = bus.mem_addr[RAM_ADDR_WIDTH+1:2];
    assign ram_wr_data     = bus.mem_wr_data;
    assign ram_wr_ena      = bus.mem_wr_ena & ~io_sel_s;
    assign led             = led_r;
    assign tx_valid        = tx_valid_r;
    assign tx_data         = fifo_mem_r[rd_ptr_r];
    assign bus.mem_rd_data = rd_data_s;

    // Read mux: RAM outside the IO page, register file inside it.
    always_comb begin
        rd_data_s = 32'd0;
        if (!io_sel_s) begin
            rd_data_s = ram_rd_data;
        end else begin
            case (word_s)
                OFF_LED:       rd_data_s = 32'(led_r);
                OFF_CYCLE:     rd_data_s = cycle_r;
                OFF_TX_DATA:   rd_data_s = 32'd0;
                OFF_TX_STATUS: rd_data_s = {16'd0, 8'(count_r), 5'd0,
                                            overflow_r, full_s, empty_s};
                default:       rd_data_s = 32'd0;
            endcase
        end
    end

    // Next FIFO occupancy; simultaneous push and pop cancel out.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Control registers, counter and FIFO bookkeeping with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            led_r      <= {LED_WIDTH{1'b0}};
            cycle_r    <= 32'd0;
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            tx_valid_r <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (led_wr_s) begin
                led_r <= bus.mem_wr_data[LED_WIDTH-1:0];
            end
            // A store to the counter wins over the increment in that cycle.
            if (cycle_wr_s) begin
                cycle_r <= bus.mem_wr_data;
            end else begin
                cycle_r <= cycle_r + 32'd1;
            end
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r    <= count_nxt_s;
            tx_valid_r <= (count_nxt_s != {CNT_W{1'b0}});
            if (status_wr_s) begin
                overflow_r <= 1'b0;
            end else if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            fifo_mem_r[wr_ptr_r] <= bus.mem_wr_data[7:0];
        end
    end

endmodule
